fetch_stage: RTL



---
 rtl/pipeline_pkg.sv | 15 +
 rtl/if_id_reg.sv | 19 +
 rtl/fetch_stage.sv | 64 ++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared RV32I pipeline defaults, the IF/ID payload type and a saturating increment helper.
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic valid;
  } if_id_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return &x ? x : x + 32'd1;
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble overrides hold, hold overrides load.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);
  localparam if_id_t BUB = '{pc: '0, pc_plus4: 32'd4, instr: NOP, valid: 1'b0};
  always_ff @(posedge clk) begin
    if (reset || bubble) q <= BUB;
    else if (en) q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, next-PC mux and redirect misalignment flag.
// Optional perf counters under FETCH_PERF_COUNTERS_EN.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC,
  parameter int XLEN_P = XLEN,
  parameter logic [31:0] NOP_INSTR_P = NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [XLEN_P-1:0] redirect_pc,
  output logic [XLEN_P-1:0] imem_addr,
  input  logic [XLEN_P-1:0] imem_instr,
  output logic [XLEN_P-1:0] if_id_pc,
  output logic [XLEN_P-1:0] if_id_pc_plus4,
  output logic [XLEN_P-1:0] if_id_instr,
  output logic              if_id_valid,
  output logic              misaligned_redirect
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flushes
`endif
);
  logic [XLEN_P-1:0] pc_q, pc_d, pc_plus4;
  logic misaligned_q;
  if_id_t if_id_d, if_id_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_d = flush ? {redirect_pc[XLEN_P-1:2], 2'b00} : stall ? pc_q : pc_plus4;
  assign if_id_d = '{pc: pc_q, pc_plus4: pc_plus4, instr: imem_instr, valid: 1'b1};
  always_ff @(posedge clk) begin
    pc_q <= reset ? RESET_PC_P : pc_d;
    misaligned_q <= !reset && flush && |redirect_pc[1:0];
  end
  if_id_reg #(.NOP(NOP_INSTR_P)) u_if_id (
    .clk   (clk),
    .reset (reset),
    .en    (!stall),
    .bubble(flush),
    .d     (if_id_d),
    .q     (if_id_q)
  );
  assign imem_addr = pc_q;
  assign if_id_pc = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;
  assign misaligned_redirect = misaligned_q;
`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall_cycles <= '0;
      perf_flushes <= '0;
    end else if (flush) perf_flushes <= sat_inc(perf_flushes);
    else if (stall) perf_stall_cycles <= sat_inc(perf_stall_cycles);
    else perf_fetched <= sat_inc(perf_fetched);
  end
`endif
endmodule
